// File: rtl/turn_ctrl.sv
// rtl/turn_ctrl.sv - two-player turn sequencer: aim, flight, score, hand-over, game over
// Tracks whose turn it is, applies hit damage and declares the winner.
module turn_ctrl #(
   parameter int HP_INIT     = 4,
   parameter int HIT_DAMAGE  = 1,
   parameter int TURN_DELAY  = 30000000,
   parameter int AIM_TIMEOUT = 600000000
) (
   input  logic       clk60MHz,
   input  logic       rst,
   input  logic       start,
   input  logic       throw_flag,
   input  logic       end_throw,
   input  logic       hit,
   output logic       turn,
   output logic       throw_en,
   output logic [3:0] hp_p1,
   output logic [3:0] hp_p2,
   output logic       game_over,
   output logic       winner,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_AIM    = 3'd1,
      S_FLIGHT = 3'd2,
      S_SCORE  = 3'd3,
      S_SWITCH = 3'd4,
      S_OVER   = 3'd5
   } state_t;

   localparam logic [29:0] AIM_LAST  = 30'(AIM_TIMEOUT - 1);
   localparam logic [29:0] TURN_LAST = 30'(TURN_DELAY - 1);
   localparam logic [3:0]  HP_RELOAD = 4'(HP_INIT);
   localparam logic [3:0]  DAMAGE    = 4'(HIT_DAMAGE);

   state_t      r_state;
   state_t      w_next;
   logic [29:0] r_count;
   logic        r_hit_l;
   logic        r_turn;
   logic        r_throw_en;
   logic [3:0]  r_hp_p1;
   logic [3:0]  r_hp_p2;
   logic        r_game_over;
   logic        r_winner;
   logic [3:0]  w_victim_hp;
   logic [3:0]  w_victim_after;

   // The opponent of the current thrower takes the damage, saturating at zero.
   always_comb begin
      w_victim_hp    = r_turn ? r_hp_p1 : r_hp_p2;
      w_victim_after = w_victim_hp;
      if (r_hit_l) begin
         w_victim_after = (w_victim_hp > DAMAGE) ? (w_victim_hp - DAMAGE) : 4'd0;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_AIM;
         S_AIM: begin
            if (throw_flag)               w_next = S_FLIGHT;
            else if (r_count == AIM_LAST) w_next = S_SWITCH;
         end
         S_FLIGHT: if (end_throw) w_next = S_SCORE;
         S_SCORE:  w_next = (w_victim_after == 4'd0) ? S_OVER : S_SWITCH;
         S_SWITCH: if (r_count == TURN_LAST) w_next = S_AIM;
         S_OVER:   if (start) w_next = S_AIM;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk60MHz) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_hit_l     <= 1'b0;
         r_turn      <= 1'b0;
         r_throw_en  <= 1'b0;
         r_hp_p1     <= HP_RELOAD;
         r_hp_p2     <= HP_RELOAD;
         r_game_over <= 1'b0;
         r_winner    <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_throw_en  <= (w_next == S_AIM);
         r_game_over <= (w_next == S_OVER);
         // One counter serves both the aim timeout and the hand-over pause.
         if (w_next != r_state) begin
            r_count <= '0;
         end else if (r_state == S_AIM || r_state == S_SWITCH) begin
            r_count <= r_count + 30'd1;
         end
         case (r_state)
            S_FLIGHT: if (hit) r_hit_l <= 1'b1;
            S_SCORE: begin
               r_hit_l <= 1'b0;
               if (r_turn) r_hp_p1 <= w_victim_after;
               else        r_hp_p2 <= w_victim_after;
               if (w_next == S_OVER) r_winner <= r_turn;
            end
            S_SWITCH: if (w_next == S_AIM) r_turn <= ~r_turn;
            S_OVER: begin
               if (start) begin
                  r_hp_p1 <= HP_RELOAD;
                  r_hp_p2 <= HP_RELOAD;
                  r_turn  <= 1'b0;
                  r_hit_l <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign phase     = r_state;
   assign turn      = r_turn;
   assign throw_en  = r_throw_en;
   assign hp_p1     = r_hp_p1;
   assign hp_p2     = r_hp_p2;
   assign game_over = r_game_over;
   assign winner    = r_winner;

endmodule

// File: tb/tb_turn_ctrl.sv
// tb/tb_turn_ctrl.sv - directed vector bench for turn_ctrl
// Outputs are packed as {phase, turn, throw_en, hp_p1, hp_p2, game_over, winner}.
module tb_turn_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: HP 4, damage 1
   logic       a_rst, a_start, a_tf, a_et, a_hit;
   logic       a_turn, a_te, a_go, a_win;
   logic [3:0] a_hp1, a_hp2;
   logic [2:0] a_phase;
   // DUT B: HP 2, damage 3 (saturation and game-over paths)
   logic       b_rst, b_start, b_tf, b_et, b_hit;
   logic       b_turn, b_te, b_go, b_win;
   logic [3:0] b_hp1, b_hp2;
   logic [2:0] b_phase;

   turn_ctrl #(.HP_INIT(4), .HIT_DAMAGE(1), .TURN_DELAY(4), .AIM_TIMEOUT(8)) u_dut_a (
      .clk60MHz(clk), .rst(a_rst), .start(a_start), .throw_flag(a_tf),
      .end_throw(a_et), .hit(a_hit), .turn(a_turn), .throw_en(a_te),
      .hp_p1(a_hp1), .hp_p2(a_hp2), .game_over(a_go), .winner(a_win), .phase(a_phase)
   );

   turn_ctrl #(.HP_INIT(2), .HIT_DAMAGE(3), .TURN_DELAY(4), .AIM_TIMEOUT(8)) u_dut_b (
      .clk60MHz(clk), .rst(b_rst), .start(b_start), .throw_flag(b_tf),
      .end_throw(b_et), .hit(b_hit), .turn(b_turn), .throw_en(b_te),
      .hp_p1(b_hp1), .hp_p2(b_hp2), .game_over(b_go), .winner(b_win), .phase(b_phase)
   );

   logic [14:0] a_out, b_out;
   assign a_out = {a_phase, a_turn, a_te, a_hp1, a_hp2, a_go, a_win};
   assign b_out = {b_phase, b_turn, b_te, b_hp1, b_hp2, b_go, b_win};

   typedef struct {
      logic [4:0]  in;   // {rst, start, throw_flag, end_throw, hit}
      logic [14:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [14:0] pk(input logic [2:0] ph, input logic tu, input logic te,
                                      input logic [3:0] h1, input logic [3:0] h2,
                                      input logic go, input logic w);
      return {ph, tu, te, h1, h2, go, w};
   endfunction

   task automatic add(input logic [4:0] in, input logic [2:0] ph, input logic tu, input logic te,
                      input logic [3:0] h1, input logic [3:0] h2, input logic go, input logic w);
      vec_t v;
      v.in  = in;
      v.exp = pk(ph, tu, te, h1, h2, go, w);
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got ph=%0d turn=%0b te=%0b hp=%0d/%0d go=%0b win=%0b, want ph=%0d turn=%0b te=%0b hp=%0d/%0d go=%0b win=%0b",
                  name, act[14:12], act[11], act[10], act[9:6], act[5:2], act[1], act[0],
                  exp[14:12], exp[11], exp[10], exp[9:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   task automatic step_a(input logic [4:0] in);
      @(negedge clk);
      {a_rst, a_start, a_tf, a_et, a_hit} = in;
      @(posedge clk);
      #1;
   endtask

   task automatic step_b(input logic [4:0] in);
      @(negedge clk);
      {b_rst, b_start, b_tf, b_et, b_hit} = in;
      @(posedge clk);
      #1;
   endtask

   initial begin
      {a_rst, a_start, a_tf, a_et, a_hit} = 5'b10000;
      {b_rst, b_start, b_tf, b_et, b_hit} = 5'b10000;

      // reset, start, hit on P2, hand-over to P1
      add(5'b10000, 3'd0, 0, 0, 4, 4, 0, 0);
      add(5'b00000, 3'd0, 0, 0, 4, 4, 0, 0);
      add(5'b01000, 3'd1, 0, 1, 4, 4, 0, 0);
      add(5'b00100, 3'd2, 0, 0, 4, 4, 0, 0);
      add(5'b00101, 3'd2, 0, 0, 4, 4, 0, 0);
      add(5'b00010, 3'd3, 0, 0, 4, 4, 0, 0);
      add(5'b00000, 3'd4, 0, 0, 4, 3, 0, 0);
      add(5'b00000, 3'd4, 0, 0, 4, 3, 0, 0);
      add(5'b00011, 3'd4, 0, 0, 4, 3, 0, 0);
      add(5'b00000, 3'd4, 0, 0, 4, 3, 0, 0);
      add(5'b00000, 3'd1, 1, 1, 4, 3, 0, 0);
      // AIM timeout: 8 cycles in AIM, then forfeit with no damage
      add(5'b00000, 3'd1, 1, 1, 4, 3, 0, 0);
      add(5'b00011, 3'd1, 1, 1, 4, 3, 0, 0);
      for (int i = 0; i < 5; i++) add(5'b00000, 3'd1, 1, 1, 4, 3, 0, 0);
      add(5'b00000, 3'd4, 1, 0, 4, 3, 0, 0);
      for (int i = 0; i < 3; i++) add(5'b00000, 3'd4, 1, 0, 4, 3, 0, 0);
      add(5'b00000, 3'd1, 0, 1, 4, 3, 0, 0);
      // start in FLIGHT ignored; hit and end_throw together count as a hit
      add(5'b00100, 3'd2, 0, 0, 4, 3, 0, 0);
      add(5'b01000, 3'd2, 0, 0, 4, 3, 0, 0);
      add(5'b00011, 3'd3, 0, 0, 4, 3, 0, 0);
      add(5'b00000, 3'd4, 0, 0, 4, 2, 0, 0);
      for (int i = 0; i < 3; i++) add(5'b00000, 3'd4, 0, 0, 4, 2, 0, 0);
      add(5'b00000, 3'd1, 1, 1, 4, 2, 0, 0);
      // throw_flag on the timeout cycle wins; miss leaves HP alone
      for (int i = 0; i < 7; i++) add(5'b00000, 3'd1, 1, 1, 4, 2, 0, 0);
      add(5'b00100, 3'd2, 1, 0, 4, 2, 0, 0);
      add(5'b00010, 3'd3, 1, 0, 4, 2, 0, 0);
      add(5'b00000, 3'd4, 1, 0, 4, 2, 0, 0);

      foreach (vecs[i]) begin
         step_a(vecs[i].in);
         chk($sformatf("vec%0d", i), a_out, vecs[i].exp);
      end

      // reset during FLIGHT aborts at once
      for (int i = 0; i < 3; i++) step_a(5'b00000);
      step_a(5'b00000);
      chk("a_back_to_p1", a_out, pk(3'd1, 0, 1, 4, 2, 0, 0));
      step_a(5'b00100);
      chk("a_flight", a_out, pk(3'd2, 0, 0, 4, 2, 0, 0));
      step_a(5'b10000);
      chk("a_rst_in_flight", a_out, pk(3'd0, 0, 0, 4, 4, 0, 0));
      step_a(5'b00000);

      // DUT B: saturating kill, OVER, restart, P2 wins
      step_b(5'b10000);
      chk("b_reset", b_out, pk(3'd0, 0, 0, 2, 2, 0, 0));
      step_b(5'b01000);
      step_b(5'b00100);
      step_b(5'b00011);
      chk("b_score", b_out, pk(3'd3, 0, 0, 2, 2, 0, 0));
      step_b(5'b00000);
      chk("b_over_p1", b_out, pk(3'd5, 0, 0, 2, 0, 1, 0));
      step_b(5'b00011);
      chk("b_over_hold", b_out, pk(3'd5, 0, 0, 2, 0, 1, 0));
      step_b(5'b01000);
      chk("b_restart", b_out, pk(3'd1, 0, 1, 2, 2, 0, 0));
      for (int i = 0; i < 8; i++) step_b(5'b00000);
      chk("b_forfeit", b_out, pk(3'd4, 0, 0, 2, 2, 0, 0));
      for (int i = 0; i < 4; i++) step_b(5'b00000);
      chk("b_p2_aim", b_out, pk(3'd1, 1, 1, 2, 2, 0, 0));
      step_b(5'b00100);
      step_b(5'b00011);
      step_b(5'b00000);
      chk("b_over_p2", b_out, pk(3'd5, 1, 0, 0, 2, 1, 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
